// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   state_t       : FSM state encoding (IDLE / CALC / DONE)
//   DEFAULT_WIDTH : default operand width
//   cnt_width()   : width of the iteration counter for a given operand width
package seq_mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must be able to represent 0..WIDTH.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_mult_ctrl_ripple_adder_n.sv
// WIDTH-bit ripple-carry adder built from a chain of full_adder cells.
//   a, b  : addends (WIDTH bits)
//   c_in  : carry into bit 0
//   s     : sum (WIDTH bits)
//   c_out : carry out of the top bit

// Single-bit full adder cell.
//   a, b, c_in : inputs
//   s, c_out   : sum and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module ripple_adder_n
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);
    // carry_s[i] is the carry into bit i; carry_s[WIDTH] leaves the adder.
    logic [WIDTH:0] carry_s;

    assign carry_s[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry_s[i]),
            .s     (s[i]),
            .c_out (carry_s[i+1])
        );
    end

    assign c_out = carry_s[WIDTH];
endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier controller.
// One ripple adder is reused for WIDTH iterations to form a 2*WIDTH-bit
// product; the result is returned together with a one-cycle done pulse.
//   clock   : system clock, rising edge
//   reset   : asynchronous, active-high reset
//   start   : request, sampled only in IDLE
//   a, b    : multiplicand / multiplier, latched on an accepted start
//   busy    : high during CALC and DONE
//   done    : one-cycle pulse in the cycle the new product is visible
//   product : registered result, held until the next completion
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t               state_r;
    state_t               state_next_s;
    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     acc_hi_r;
    logic [WIDTH-1:0]     acc_lo_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 busy_r;
    logic                 done_r;
    logic [2*WIDTH-1:0]   product_r;
    logic                 busy_next_s;
    logic                 done_next_s;
    logic [WIDTH-1:0]     addend_s;
    logic [WIDTH-1:0]     sum_s;
    logic                 cout_s;
    logic [2*WIDTH-1:0]   acc_next_s;

    // The multiplier bit in acc_lo[0] decides whether mcand is added this step.
    assign addend_s = acc_lo_r[0] ? mcand_r : {WIDTH{1'b0}};

    ripple_adder_n #(.WIDTH(WIDTH)) u_adder (
        .a     (acc_hi_r),
        .b     (addend_s),
        .c_in  (1'b0),
        .s     (sum_s),
        .c_out (cout_s)
    );

    // The carry-out becomes the new top bit after the right shift; the
    // consumed multiplier bit falls off the bottom.
    assign acc_next_s = {cout_s, sum_s, acc_lo_r[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so the registered flags line up
    // exactly with the state they describe.
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
            ST_CALC: begin
                busy_next_s = 1'b1;
                done_next_s = 1'b0;
            end
            ST_DONE: begin
                busy_next_s = 1'b1;
                done_next_s = 1'b1;
            end
            default: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
        endcase
    end

    // Output flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            done_r <= done_next_s;
        end
    end

    // Operand latch, shift/accumulate datapath, iteration counter and product.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_r   <= {WIDTH{1'b0}};
            acc_hi_r  <= {WIDTH{1'b0}};
            acc_lo_r  <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mcand_r  <= a;
                        acc_lo_r <= b;
                        acc_hi_r <= {WIDTH{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                    end else begin
                        mcand_r  <= mcand_r;
                        acc_lo_r <= acc_lo_r;
                        acc_hi_r <= acc_hi_r;
                        cnt_r    <= cnt_r;
                    end
                end
                ST_CALC: begin
                    acc_hi_r <= acc_next_s[2*WIDTH-1:WIDTH];
                    acc_lo_r <= acc_next_s[WIDTH-1:0];
                    cnt_r    <= cnt_r + CNT_ONE;
                    // The final iteration's result goes straight to product
                    // on the edge that enters DONE.
                    if (cnt_r == CNT_LAST) begin
                        product_r <= acc_next_s;
                    end else begin
                        product_r <= product_r;
                    end
                end
                default: begin
                    mcand_r   <= mcand_r;
                    acc_hi_r  <= acc_hi_r;
                    acc_lo_r  <= acc_lo_r;
                    cnt_r     <= cnt_r;
                    product_r <= product_r;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl (WIDTH=4). A reference model samples the
// inputs at each rising edge and queues the expected product for every
// accepted start; a monitor checks busy/done/product every cycle and pops the
// queue when a completion is due.
module tb_seq_mult_ctrl;
    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int            cyc      = 0;
    int            last_acc = 0;
    bit            op_live  = 1'b0;
    logic [PW-1:0] exp_q[$];

    seq_mult_ctrl #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: an operation is accepted on an edge with start=1 once
    // WIDTH+2 edges have passed since the previous acceptance.
    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            if (reset) begin
                exp_q.delete();
                op_live = 1'b0;
            end else if (start && (!op_live || (cyc - last_acc) >= W + 2)) begin
                last_acc = cyc;
                op_live  = 1'b1;
                exp_q.push_back(PW'(a) * PW'(b));
            end
        end
    end

    // Monitor: busy during the W+1 cycles after acceptance, done in the last.
    initial begin
        logic [PW-1:0] exp_hold;
        bit            busy_exp;
        bit            done_exp;
        exp_hold = '0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                exp_hold = '0;
                chk("reset_busy", 32'(busy), 32'd0);
                chk("reset_done", 32'(done), 32'd0);
                chk("reset_product", 32'(product), 32'd0);
            end else begin
                busy_exp = op_live && ((cyc - last_acc) <= W);
                done_exp = op_live && ((cyc - last_acc) == W);
                if (done_exp) begin
                    if (exp_q.size() > 0) begin
                        exp_hold = exp_q.pop_front();
                    end else begin
                        chk("scoreboard_underflow", 32'd0, 32'd1);
                    end
                end
                chk("busy", 32'(busy), 32'(busy_exp));
                chk("done", 32'(done), 32'(done_exp));
                chk("product", 32'(product), 32'(exp_hold));
            end
        end
    end

    // Inputs change 2 time units after a rising edge (between edges).
    task automatic tick(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic r);
        @(posedge clock);
        #2;
        start = s;
        a     = aa;
        b     = bb;
        reset = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, a, b, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ops_a [6] = '{4'd3, 4'd15, 4'd15, 4'd8, 4'd0, 4'd9};
        logic [W-1:0] ops_b [6] = '{4'd5, 4'd15, 4'd1,  4'd15, 4'd9, 4'd0};

        // Reset held for a few edges, then released.
        tick(1'b0, 4'd0, 4'd0, 1'b1);
        tick(1'b0, 4'd0, 4'd0, 1'b1);
        idle(2);

        // Directed operand pairs, including carry-heavy and zero cases.
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, ops_a[i], ops_b[i], 1'b0);
            idle(7);
        end

        // start and operand changes while busy are ignored.
        tick(1'b1, 4'd2, 4'd7, 1'b0);
        for (int i = 0; i < W + 1; i++) tick(1'b1, 4'd15, 4'd15, 1'b0);
        idle(8);

        // Asynchronous reset after two CALC cycles.
        tick(1'b1, 4'd15, 4'd15, 1'b0);
        idle(2);
        #1 reset = 1'b1;
        idle(2);
        @(posedge clock);
        #2 reset = 1'b0;
        tick(1'b1, 4'd6, 4'd7, 1'b0);
        idle(7);

        // Back-to-back with start held high.
        for (int i = 0; i < 20; i++) tick(1'b1, 4'd5, 4'd5, 1'b0);
        idle(8);

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 2) == 0), W'($urandom), W'($urandom),
                 ($urandom_range(0, 99) == 0));
        end
        idle(8);

        // Exhaustive sweep of all operand pairs.
        for (int i = 0; i < (1 << W); i++) begin
            for (int j = 0; j < (1 << W); j++) begin
                tick(1'b1, W'(i), W'(j), 1'b0);
                idle(5);
            end
        end
        idle(8);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
